// File: rtl/mp_banked_sram.sv
`default_nettype none
// ============================================================================
// Module      : mp_banked_sram
// Description : NPORTS-requester SRAM over NBANKS address-interleaved banks,
//               each bank with a round-robin arbiter and same-cycle grant.
//               Optional macro RD_REG_EN adds an output register stage
//               (read latency 2 instead of 1).
// Revision    : 1.0
// ============================================================================
module mp_banked_sram #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 15,
    parameter int NPORTS = 4,
    parameter int NBANKS = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NPORTS-1:0]        req_in,
    input  logic [NPORTS-1:0]        we_in,
    input  logic [NPORTS*AWIDTH-1:0] addr_in,
    input  logic [NPORTS*DWIDTH-1:0] d_in,
    output logic [NPORTS-1:0]        gnt_out,
    output logic [NPORTS-1:0]        rvalid_out,
    output logic [NPORTS*DWIDTH-1:0] d_out
);

    localparam int C_BSEL  = (NBANKS > 1) ? $clog2(NBANKS) : 0;
    localparam int C_BW    = (C_BSEL > 0) ? C_BSEL : 1;
    localparam int C_ROWS  = AWIDTH - C_BSEL;
    localparam int C_RW    = (C_ROWS > 0) ? C_ROWS : 1;
    localparam int C_DEPTH = 1 << C_ROWS;
    localparam int C_PW    = $clog2(NPORTS);

    logic [C_BW-1:0]          w_pbank [NPORTS];
    logic [C_RW-1:0]          w_prow  [NPORTS];
    logic [NBANKS*NPORTS-1:0] w_bgnt;
    logic [NBANKS-1:0]        w_brvld;
    logic [NBANKS*C_PW-1:0]   w_bsrc;
    logic [NBANKS*DWIDTH-1:0] w_brdata;
    logic [NPORTS-1:0]        w_rvalid;
    logic [NPORTS*DWIDTH-1:0] w_rdata;
    logic [NPORTS*DWIDTH-1:0] hold_q;

    // Split each port address into bank select (low bits) and row (high bits).
    for (genvar p = 0; p < NPORTS; p++) begin : g_port_dec
        if (C_BSEL > 0) begin : g_bank_sel
            assign w_pbank[p] = addr_in[p*AWIDTH +: C_BW];
        end else begin : g_one_bank
            assign w_pbank[p] = '0;
        end
        if (C_ROWS > 0) begin : g_row
            assign w_prow[p] = addr_in[p*AWIDTH + C_BSEL +: C_RW];
        end else begin : g_no_row
            assign w_prow[p] = '0;
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [NPORTS-1:0] w_req;
        logic [NPORTS-1:0] w_gnt;
        logic [C_PW-1:0]   ptr_q;
        logic [C_PW-1:0]   ptr_d;
        logic [C_PW-1:0]   w_win;
        logic              w_act;
        logic              w_we;
        logic [C_RW-1:0]   w_row;
        logic [DWIDTH-1:0] w_wdata;
        logic              rvld_q;
        logic [C_PW-1:0]   src_q;
        logic [DWIDTH-1:0] rdata_q;
        logic [DWIDTH-1:0] mem [C_DEPTH];

        always_comb begin
            w_req = '0;
            for (int p = 0; p < NPORTS; p++) begin
                w_req[p] = req_in[p] & ~rst_in & (w_pbank[p] == C_BW'(b));
            end
        end

        // Scan from the pointer upward with wrap; first requester wins.
        always_comb begin
            int              idx;
            logic [C_PW-1:0] sel;
            idx   = 0;
            sel   = '0;
            w_act = 1'b0;
            w_win = '0;
            for (int i = 0; i < NPORTS; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NPORTS) begin
                    idx = idx - NPORTS;
                end
                sel = C_PW'(idx);
                if (!w_act && w_req[sel]) begin
                    w_act = 1'b1;
                    w_win = sel;
                end
            end
        end

        always_comb begin
            w_gnt = '0;
            if (w_act) begin
                w_gnt[w_win] = 1'b1;
            end
        end

        always_comb begin
            ptr_d = ptr_q;
            if (w_act) begin
                ptr_d = (int'(w_win) == NPORTS - 1) ? '0 : w_win + 1'b1;
            end
        end

        assign w_we    = we_in[w_win];
        assign w_row   = w_prow[w_win];
        assign w_wdata = d_in[w_win*DWIDTH +: DWIDTH];

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                ptr_q  <= '0;
                rvld_q <= 1'b0;
                src_q  <= '0;
            end else begin
                ptr_q  <= ptr_d;
                rvld_q <= w_act & ~w_we;
                if (w_act && !w_we) begin
                    src_q <= w_win;
                end
            end
        end

        // Storage is never reset; w_act is already suppressed during reset.
        always_ff @(posedge clk_in) begin
            if (w_act) begin
                if (w_we) begin
                    mem[w_row] <= w_wdata;
                end else begin
                    rdata_q <= mem[w_row];
                end
            end
        end

        assign w_bgnt[b*NPORTS +: NPORTS]   = w_gnt;
        assign w_brvld[b]                   = rvld_q;
        assign w_bsrc[b*C_PW +: C_PW]       = src_q;
        assign w_brdata[b*DWIDTH +: DWIDTH] = rdata_q;
    end

    always_comb begin
        gnt_out = '0;
        for (int b = 0; b < NBANKS; b++) begin
            gnt_out = gnt_out | w_bgnt[b*NPORTS +: NPORTS];
        end
    end

    // A port owns at most one bank read per cycle, so at most one bank matches.
    always_comb begin
        w_rvalid = '0;
        w_rdata  = hold_q;
        for (int p = 0; p < NPORTS; p++) begin
            for (int b = 0; b < NBANKS; b++) begin
                if (w_brvld[b] && (w_bsrc[b*C_PW +: C_PW] == C_PW'(p))) begin
                    w_rvalid[p]                = 1'b1;
                    w_rdata[p*DWIDTH +: DWIDTH] = w_brdata[b*DWIDTH +: DWIDTH];
                end
            end
        end
        if (rst_in) begin
            w_rvalid = '0;
            w_rdata  = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_q <= '0;
        end else begin
            hold_q <= w_rdata;
        end
    end

`ifdef RD_REG_EN
    logic [NPORTS-1:0]        rv_out_q;
    logic [NPORTS*DWIDTH-1:0] d_out_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rv_out_q <= '0;
            d_out_q  <= '0;
        end else begin
            rv_out_q <= w_rvalid;
            d_out_q  <= w_rdata;
        end
    end

    assign rvalid_out = rst_in ? '0 : rv_out_q;
    assign d_out      = rst_in ? '0 : d_out_q;
`else
    assign rvalid_out = w_rvalid;
    assign d_out      = w_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_banked_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_banked_sram
// Description : Scoreboard bench for mp_banked_sram with a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_mp_banked_sram;
    localparam int DW = 32;
    localparam int AW = 15;
    localparam int NP = 4;
    localparam int NB = 4;
`ifdef RD_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          cyc;
        bit          known;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req, we, gnt, rvalid;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  din, dout;

    mp_banked_sram #(.DWIDTH(DW), .AWIDTH(AW), .NPORTS(NP), .NBANKS(NB)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .req_in     (req),
        .we_in      (we),
        .addr_in    (addr),
        .d_in       (din),
        .gnt_out    (gnt),
        .rvalid_out (rvalid),
        .d_out      (dout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Requester state (held until granted)
    bit            p_req  [NP];
    bit            p_we   [NP];
    logic [AW-1:0] p_addr [NP];
    logic [DW-1:0] p_d    [NP];

    // Reference model
    logic [DW-1:0] mem_m [int];
    int            ptr_m [NB];
    exp_t          expq  [NP][$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[p] = 1'b1; p_we[p] = w; p_addr[p] = a; p_d[p] = d;
    endtask

    task automatic clear_ports();
        for (int p = 0; p < NP; p++) p_req[p] = 1'b0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return AW'($urandom_range(0, 31));
        if (r < 8) return AW'(32'h7FE0 + $urandom_range(0, 31));
        return AW'($urandom);
    endfunction

    // Round-robin per bank from the model pointer; updates the pointers.
    task automatic model_arb(output logic [NP-1:0] g);
        bit found;
        int p;
        g = '0;
        if (rst) return;
        for (int b = 0; b < NB; b++) begin
            found = 1'b0;
            for (int i = 0; i < NP; i++) begin
                p = (ptr_m[b] + i) % NP;
                if (!found && p_req[p] && (int'(p_addr[p]) % NB == b)) begin
                    found = 1'b1;
                    g[p]  = 1'b1;
                    ptr_m[b] = (p + 1) % NP;
                end
            end
        end
    endtask

    task automatic step(input bit rnd, input bit r, output logic [NP-1:0] g);
        logic [NP-1:0] eg;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        if (r) begin
            for (int p = 0; p < NP; p++) expq[p].delete();
            for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        end
        if (rnd && !r) begin
            for (int p = 0; p < NP; p++) begin
                if (!p_req[p] && $urandom_range(0, 1) == 1)
                    set_port(p, bit'($urandom_range(0, 1)), pick_addr(), $urandom);
            end
        end
        for (int p = 0; p < NP; p++) begin
            req[p]               = p_req[p];
            we[p]                = p_we[p];
            addr[p*AW +: AW]     = p_addr[p];
            din[p*DW +: DW]      = p_d[p];
        end
        @(negedge clk);
        model_arb(eg);
        chk("gnt", {60'd0, gnt}, {60'd0, eg});
        for (int p = 0; p < NP; p++) begin
            if (eg[p]) begin
                if (p_we[p]) begin
                    mem_m[int'(p_addr[p])] = p_d[p];
                end else begin
                    e.cyc   = cyc + LAT;
                    e.known = mem_m.exists(int'(p_addr[p]));
                    e.data  = e.known ? mem_m[int'(p_addr[p])] : '0;
                    expq[p].push_back(e);
                end
                p_req[p] = 1'b0;
            end
        end
        g = gnt;
    endtask

    // Monitor: pops expected reads on rvalid and tracks d_out hold value.
    logic [DW-1:0] last_d  [NP];
    bit            last_ok [NP];
    initial begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin last_d[p] = '0; last_ok[p] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (rst === 1'b1) begin last_d[p] = '0; last_ok[p] = 1'b1; end
                if (rvalid[p] === 1'b1) begin
                    checks++;
                    if (expq[p].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rvalid port=%0d cycle=%0d", p, cyc);
                    end else begin
                        e = expq[p].pop_front();
                        if (e.cyc != cyc || (e.known && dout[p*DW +: DW] !== e.data)) begin
                            failures++;
                            $display("FAIL rdata port=%0d got cycle=%0d data=%0h expected cycle=%0d data=%0h known=%0d",
                                     p, cyc, dout[p*DW +: DW], e.cyc, e.data, e.known);
                        end
                        last_d[p]  = e.data;
                        last_ok[p] = e.known;
                    end
                end else begin
                    if (expq[p].size() != 0 && expq[p][0].cyc <= cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL missing_rvalid port=%0d due=%0d cycle=%0d", p, expq[p][0].cyc, cyc);
                        void'(expq[p].pop_front());
                    end
                    if (last_ok[p]) chk("dout_hold", {32'd0, dout[p*DW +: DW]}, {32'd0, last_d[p]});
                end
            end
        end
    end

    initial begin
        logic [NP-1:0] g;
        bit            seen;
        int            seq [6] = '{1, 3, 1, 3, 1, 3};
        rst = 1'b1; req = '0; we = '0; addr = '0; din = '0;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        clear_ports();
        for (int p = 0; p < NP; p++) begin p_we[p] = 0; p_addr[p] = '0; p_d[p] = '0; end
        step(0, 1, g);

        // Reset with every port requesting a write
        for (int p = 0; p < NP; p++) set_port(p, 1, AW'(p), 32'h55);
        step(0, 1, g);
        chk("reset_gnt", {60'd0, g}, 64'd0);
        chk("reset_rvalid", {60'd0, rvalid}, 64'd0);
        chk("reset_dout", dout[63:0], 64'd0);
        clear_ports();
        step(0, 0, g);

        // No conflict: four banks in parallel
        for (int p = 0; p < NP; p++) set_port(p, 1, AW'(p), 32'hA0 + p);
        step(0, 0, g);
        chk("noconf_wr_gnt", {60'd0, g}, 64'hF);
        for (int p = 0; p < NP; p++) set_port(p, 0, AW'(p), '0);
        step(0, 0, g);
        chk("noconf_rd_gnt", {60'd0, g}, 64'hF);
        for (int i = 0; i < 3; i++) step(0, 0, g);

        // Writes attempted during reset must not reach the array
        for (int p = 0; p < NP; p++) set_port(p, 1, AW'(p), 32'h55);
        step(0, 1, g);
        clear_ports();
        step(0, 0, g);
        for (int p = 0; p < NP; p++) set_port(p, 0, AW'(p), '0);
        step(0, 0, g);
        for (int i = 0; i < 3; i++) step(0, 0, g);

        // Full conflict on bank 0 from fresh pointers
        for (int k = 1; k <= 4; k++) begin
            set_port(0, 1, AW'(4 * k), 32'h1000 + 4 * k);
            step(0, 0, g);
        end
        step(0, 1, g);
        step(0, 0, g);
        for (int p = 0; p < NP; p++) set_port(p, 0, AW'(4 * (p + 1)), '0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, g);
            chk("conflict_gnt", {60'd0, g}, 64'd1 << k);
        end
        for (int i = 0; i < 3; i++) step(0, 0, g);

        // Fairness: ports 1 and 3 keep bank 2 busy
        for (int k = 0; k < 6; k++) begin
            if (!p_req[1]) set_port(1, 0, AW'(2), '0);
            if (!p_req[3]) set_port(3, 1, AW'(10), 32'hB0 + k);
            step(0, 0, g);
            chk("rr_gnt", {60'd0, g}, 64'd1 << seq[k]);
        end
        for (int i = 0; i < 3; i++) step(0, 0, g);

        // Write then read at the top address
        set_port(0, 1, AW'(15'h7FFF), 32'hDEADBEEF);
        step(0, 0, g);
        set_port(2, 0, AW'(15'h7FFF), '0);
        step(0, 0, g);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(0, 0, g);
            if (rvalid[2] === 1'b1) begin
                seen = 1'b1;
                chk("wtr_data", {32'd0, dout[2*DW +: DW]}, 64'hDEADBEEF);
            end
        end
        if (!seen) chk("wtr_timeout", 64'd0, 64'd1);

        // Reset right after a granted read
        set_port(1, 0, AW'(5), '0);
        step(0, 0, g);
        step(0, 1, g);
        chk("rst_mid_rvalid", {60'd0, rvalid}, 64'd0);
        step(0, 0, g);
        chk("rst_mid_rvalid2", {60'd0, rvalid}, 64'd0);
        set_port(1, 0, AW'(1), '0);
        set_port(3, 0, AW'(9), '0);
        step(0, 0, g);
        chk("ptr_reset_gnt", {60'd0, g}, 64'h2);
        for (int i = 0; i < 4; i++) step(0, 0, g);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(0, 1, g);
                clear_ports();
            end else begin
                step(1, 0, g);
            end
        end
        for (int i = 0; i < 20; i++) step(0, 0, g);
        for (int i = 0; i < 4; i++) step(0, 0, g);
        for (int p = 0; p < NP; p++) chk("drain_empty", 64'(expq[p].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mp_banked_sram.md
# mp_banked_sram

Single-clock, multi-port banked SRAM for the MultiPortCache data store. It generalises the two-port SRAM to NPORTS requesters sharing NBANKS address-interleaved banks. Each bank has a round-robin arbiter and a valid/grant handshake. Read data returns per port at a fixed latency, tagged by a valid strobe. It sits between the port front-ends and cache storage.

## Interface
- DWIDTH, 32, data width per port
- AWIDTH, 15, word address width; total depth 2^AWIDTH words
- NPORTS, 4, number of requester ports (2..8)
- NBANKS, 4, number of banks; power of two, 1..2^AWIDTH

Ports:
- clk_in  in  1  the single clock
- rst_in  in  1  synchronous, active-high reset
- req_in  in  NPORTS  per-port request
- we_in  in  NPORTS  per-port write enable (1 = write, 0 = read)
- addr_in  in  NPORTS*AWIDTH  per-port word address; port p at [p*AWIDTH +: AWIDTH]
- d_in  in  NPORTS*DWIDTH  per-port write data
- gnt_out  out  NPORTS  per-port grant; transfer occurs when req_in[p] & gnt_out[p]
- rvalid_out  out  NPORTS  per-port read-data valid, one-cycle pulse
- d_out  out  NPORTS*DWIDTH  per-port read data

## Operation
- Bank select: addr[log2(NBANKS)-1:0]. Row: addr[AWIDTH-1:log2(NBANKS)]. Each bank holds 2^AWIDTH/NBANKS words.
- Handshake: the requester holds req/we/addr/d stable until it sees gnt_out. gnt_out is combinational from req_in and the arbiter state. No transfer occurs without a grant.
- Per-bank arbitration: round-robin among ports whose req_in is high and whose address maps to that bank. At most one grant per bank per cycle. Ports targeting different banks are all granted in the same cycle.
- Round-robin pointer: one per bank. After a grant it moves to winner+1 (mod NPORTS). It is unchanged when the bank is idle. Priority runs from the pointer upward and wraps.
- Write: the bank array is updated at the clock edge of the grant cycle.
- Read: the row is read at the grant edge and routed back to the requesting port.
- Read of an address written in an earlier cycle returns the new data. A read and a write to the same address never occur in the same cycle, because the bank is serialized.
- A port has at most one granted transfer per cycle. Back-to-back grants to the same port are allowed.
- d_out[p] holds the last read data until the next read completes for port p.
- Reset:
  - gnt_out = 0 while rst_in is high.
  - rvalid_out = 0 and d_out = 0.
  - All pointers = 0, so port 0 has priority.
  - Memory contents are not reset.
- Reset mid-operation: in-flight reads are discarded. No rvalid_out pulse follows a reset cycle.

## Timing
- Grant: same cycle as request when the port wins.
- Read latency without RD_REG_EN: rvalid_out[p] and d_out[p] are valid in cycle t+1 for a grant in cycle t.
- Read latency with RD_REG_EN: valid in cycle t+2.
- Throughput: one transfer per bank per cycle, up to min(NPORTS, NBANKS) transfers per cycle.
- Worst-case wait under full contention on one bank: NPORTS-1 cycles.
- Writes produce no rvalid_out.

## Configuration
- RD_REG_EN
  - Defined: an extra output register stage is placed on d_out/rvalid_out, giving read latency 2. Grant timing is unchanged.
  - Undefined: read latency is 1 and d_out is driven directly from the bank read register.

## Test plan
- Reset: drive rst_in high with req_in = 4'b1111 -> gnt_out = 0, rvalid_out = 0, d_out = 0. No array writes.
- No conflict:
  - Stimulus: ports 0..3 write 0xA0..0xA3 to addresses 0..3 in one cycle, then read the same addresses.
  - Required: all four granted in each cycle. Reads return 0xA0..0xA3 with rvalid after 1 cycle (2 with RD_REG_EN).
- Full bank conflict:
  - Stimulus: all ports hold read requests to addresses 4, 8, 12, 16, all in bank 0.
  - Required: grants in order port 0,1,2,3 over 4 consecutive cycles, one per cycle. Each data word returns to the correct port.
- Round-robin fairness:
  - Stimulus: ports 1 and 3 hold requests to bank 2 continuously for 6 cycles.
  - Required: grants alternate 1,3,1,3,1,3.
- Write-then-read:
  - Stimulus: port 0 writes 0xDEADBEEF to address 0x7FFF in cycle t. Port 2 reads 0x7FFF in cycle t+1.
  - Required: port 2 gets 0xDEADBEEF. The top address behaves correctly.
- Reset mid-read: assert rst_in in the cycle after a granted read -> no rvalid_out pulse, and all pointers are back to 0.
